obstacle_collision: RTL and testbench

Pixel-stream collision detector and life counter for the obstacle layer. It sits directly downstream of the obstacle drawing modules (lasers and the others) in the VGA pipeline. It compares each obstacle-layer pixel against the player's bounding box and aggregates hits once per frame. It then runs the hit, cooldown, life-loss and game-over sequence that the game controller consumes.

---
 rtl/obstacle_collision.sv | 146 ++++++++++++++
 tb/tb_obstacle_collision.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_collision.sv
// Obstacle-layer pixel collision detector with per-frame hit, cooldown and life counter.
// Optional HIT_FLASH_EN: blink the player box red during cooldown.
module obstacle_collision #(
   parameter logic [11:0] OBSTACLE_COLOR  = 12'hFFF,
   parameter int          PLAYER_SIZE     = 20,
   parameter int          LIVES           = 3,
   parameter int          COOLDOWN_FRAMES = 60,
   parameter int          H_MAX           = 1343,
   parameter int          V_MAX           = 805
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [11:0] hcount_in,
   input  logic [11:0] vcount_in,
   input  logic [11:0] rgb_in,
   input  logic [11:0] player_x,
   input  logic [11:0] player_y,
   input  logic        game_on,
   output logic [11:0] rgb_out,
   output logic        hit,
   output logic [2:0]  lives,
   output logic        game_over
);

   typedef enum logic [1:0] {IDLE, ARMED, COOLDOWN, DEAD} state_t;

   localparam logic [12:0] BOX_SPAN = 13'(PLAYER_SIZE - 1);
   localparam logic [2:0]  LIVES_L  = 3'(LIVES);
   localparam logic [5:0]  CD_L     = 6'(COOLDOWN_FRAMES);

   logic [12:0] x_hi, y_hi;
   logic        in_box, hit_px_c, frame_end_c;
   logic        hit_px_d, frame_end_d, frame_hit;
   logic [11:0] rgb_d;

   state_t      state, state_nx;
   logic [2:0]  lives_nx;
   logic [5:0]  cd_cnt, cd_nx;
   logic        hit_nx;

   // 13-bit upper bounds keep boxes near 4095 from wrapping
   assign x_hi = {1'b0, player_x} + BOX_SPAN;
   assign y_hi = {1'b0, player_y} + BOX_SPAN;

   assign in_box = (hcount_in >= player_x) && ({1'b0, hcount_in} <= x_hi) &&
                   (vcount_in >= player_y) && ({1'b0, vcount_in} <= y_hi);
   assign hit_px_c    = in_box && (rgb_in == OBSTACLE_COLOR);
   assign frame_end_c = (hcount_in == 12'(H_MAX)) && (vcount_in == 12'(V_MAX));

   always_ff @(posedge pclk) begin
      if (rst) begin
         hit_px_d    <= 1'b0;
         frame_end_d <= 1'b0;
         rgb_d       <= 12'h000;
      end else begin
         hit_px_d    <= hit_px_c;
         frame_end_d <= frame_end_c;
         rgb_d       <= rgb_in;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst || frame_end_d) frame_hit <= 1'b0;
      else if (hit_px_d)      frame_hit <= 1'b1;
   end

   always_comb begin
      state_nx = state;
      lives_nx = lives;
      cd_nx    = cd_cnt;
      hit_nx   = 1'b0;
      if (!game_on) begin
         state_nx = IDLE;
         lives_nx = LIVES_L;
         cd_nx    = 6'd0;
      end else begin
         unique case (state)
            IDLE: begin
               lives_nx = LIVES_L;
               if (frame_end_d) state_nx = ARMED;
            end
            ARMED: begin
               if (frame_end_d && (frame_hit || hit_px_d)) begin
                  hit_nx   = 1'b1;
                  lives_nx = lives - 3'd1;
                  if (lives == 3'd1) begin
                     state_nx = DEAD;
                  end else begin
                     state_nx = COOLDOWN;
                     cd_nx    = CD_L;
                  end
               end
            end
            COOLDOWN: begin
               if (frame_end_d) begin
                  if (cd_cnt == 6'd1) begin
                     state_nx = ARMED;
                     cd_nx    = 6'd0;
                  end else begin
                     cd_nx = cd_cnt - 6'd1;
                  end
               end
            end
            DEAD: lives_nx = 3'd0;
         endcase
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state  <= IDLE;
         lives  <= LIVES_L;
         cd_cnt <= 6'd0;
         hit    <= 1'b0;
      end else begin
         state  <= state_nx;
         lives  <= lives_nx;
         cd_cnt <= cd_nx;
         hit    <= hit_nx;
      end
   end

   assign game_over = (state == DEAD);

`ifdef HIT_FLASH_EN
   logic in_box_d, flash;

   always_ff @(posedge pclk) begin
      if (rst) in_box_d <= 1'b0;
      else     in_box_d <= in_box;
   end

   assign flash = (state == COOLDOWN) && cd_cnt[2] && in_box_d;

   always_ff @(posedge pclk) begin
      if (rst) rgb_out <= 12'h000;
      else     rgb_out <= flash ? 12'hF00 : rgb_d;
   end
`else
   always_ff @(posedge pclk) begin
      if (rst) rgb_out <= 12'h000;
      else     rgb_out <= rgb_d;
   end
`endif

endmodule

// File: tb/tb_obstacle_collision.sv
// Scoreboard bench for obstacle_collision: stimulus queues expected outputs,
// a negedge monitor pops and compares them cycle by cycle.
module tb_obstacle_collision;

   localparam int LV = 3;
   localparam int HM = 1343;
   localparam int VM = 805;

   logic        pclk, rst, game_on;
   logic [11:0] hcount_in, vcount_in, rgb_in, player_x, player_y;
   logic [11:0] rgb_out;
   logic        hit, game_over;
   logic [2:0]  lives;

   obstacle_collision #(
      .OBSTACLE_COLOR(12'hFFF), .PLAYER_SIZE(20), .LIVES(LV),
      .COOLDOWN_FRAMES(4), .H_MAX(HM), .V_MAX(VM)
   ) dut (
      .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .rgb_in(rgb_in), .player_x(player_x), .player_y(player_y),
      .game_on(game_on), .rgb_out(rgb_out), .hit(hit), .lives(lives),
      .game_over(game_over)
   );

   typedef struct {
      int          cyc;
      logic [11:0] rgb;
      logic        hit;
      logic [2:0]  lv;
      logic        go;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   nvec = 0;
   int   nerr = 0;

   logic        rn, gn, was_rst;
   logic [11:0] pxn, pyn;
   logic [2:0]  xl;
   logic        xg;

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   always @(posedge pclk) cyc <= cyc + 1;

   always @(negedge pclk) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
         exp_t e;
         e = q.pop_front();
         nvec++;
         if (rgb_out !== e.rgb || hit !== e.hit ||
             lives !== e.lv || game_over !== e.go) begin
            nerr++;
            $display("FAIL out@%0d: rgb=%h hit=%b lives=%0d go=%b, want rgb=%h hit=%b lives=%0d go=%b",
                     cyc, rgb_out, hit, lives, game_over, e.rgb, e.hit, e.lv, e.go);
         end
      end else if (hit !== 1'b0) begin
         nvec++;
         nerr++;
         $display("FAIL spurious_hit@%0d: hit=%b, want 0", cyc, hit);
      end
   end

   function automatic logic [11:0] fl(input logic [11:0] c);
`ifdef HIT_FLASH_EN
      return 12'hF00;
`else
      return c;
`endif
   endfunction

   task automatic push(input int c, input logic [11:0] r, input logic h,
                       input logic [2:0] l, input logic g);
      exp_t e;
      e.cyc = c; e.rgb = r; e.hit = h; e.lv = l; e.go = g;
      q.push_back(e);
   endtask

   task automatic drive(input int h, input int v, input logic [11:0] c,
                        input logic xh, input logic [11:0] xr);
      @(posedge pclk);
      #1;
      rst       = rn;
      game_on   = gn;
      player_x  = pxn;
      player_y  = pyn;
      hcount_in = 12'(h);
      vcount_in = 12'(v);
      rgb_in    = c;
      if (rn) begin
         while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
         push(cyc + 1, 12'h000, 1'b0, 3'(LV), 1'b0);
         was_rst = 1'b1;
      end else begin
         if (was_rst) push(cyc + 1, 12'h000, 1'b0, 3'(LV), 1'b0);
         was_rst = 1'b0;
         push(cyc + 2, xr, xh, xl, xg);
      end
   endtask

   task automatic px(input int h, input int v, input logic [11:0] c);
      drive(h, v, c, 1'b0, c);
   endtask

   task automatic pxe(input int h, input int v, input logic [11:0] c,
                      input logic [11:0] xr);
      drive(h, v, c, 1'b0, xr);
   endtask

   task automatic fend(input logic xh);
      drive(HM, VM, 12'h000, xh, 12'h000);
   endtask

   task automatic do_rst(input int n);
      rn = 1'b1;
      xl = 3'(LV);
      xg = 1'b0;
      repeat (n) px(0, 0, 12'h000);
      rn = 1'b0;
   endtask

   // game_on acts one cycle after it is driven, one cycle ahead of pixels
   task automatic drop_game();
      exp_t e;
      gn = 1'b0;
      if (q.size() > 0) begin
         e = q.pop_back();
         e.lv = 3'(LV); e.go = 1'b0; e.hit = 1'b0;
         q.push_back(e);
      end
      xl = 3'(LV);
      xg = 1'b0;
      px(0, 0, 12'h000);
   endtask

   initial begin
      rst = 1'b1; game_on = 1'b0;
      hcount_in = '0; vcount_in = '0; rgb_in = '0;
      player_x = 12'd400; player_y = 12'd400;
      rn = 1'b1; gn = 1'b0; was_rst = 1'b0;
      pxn = 12'd400; pyn = 12'd400; xl = 3'(LV); xg = 1'b0;

      do_rst(2);

      // in-box hit while IDLE must not count
      gn = 1'b1;
      px(405, 410, 12'hFFF);
      fend(1'b0);

      // overlap: one hit, lives 3->2
      px(100, 100, 12'hFFF);
      px(405, 410, 12'hFFF);
      px(300, 300, 12'hABC);
      xl = 3'd2;
      fend(1'b1);

      // cooldown frames with hits every frame
      pxe(405, 410, 12'hFFF, fl(12'hFFF));
      pxe(410, 415, 12'h0F0, fl(12'h0F0));
      px(399, 410, 12'hFFF);
      fend(1'b0);
      repeat (3) begin
         px(405, 410, 12'hFFF);
         fend(1'b0);
      end
      px(419, 419, 12'hFFF);
      xl = 3'd1;
      fend(1'b1);

      pxe(419, 419, 12'hFFF, fl(12'hFFF));
      fend(1'b0);
      repeat (3) fend(1'b0);

      // 500 hit pixels, final life lost once
      for (int i = 0; i < 500; i++)
         px(400 + i % 20, 400 + (i / 20) % 20, 12'hFFF);
      xl = 3'd0;
      xg = 1'b1;
      fend(1'b1);

      px(405, 410, 12'hFFF);
      fend(1'b0);
      drop_game();

      // game_on drop beats a pending frame_end hit
      gn = 1'b1;
      fend(1'b0);
      px(405, 410, 12'hFFF);
      fend(1'b0);
      drop_game();

      // right-edge box near 4095
      gn = 1'b1;
      pxn = 12'd4090;
      fend(1'b0);
      px(4095, 405, 12'hFFF);
      xl = 3'd2;
      fend(1'b1);
      repeat (4) fend(1'b0);

      // one pixel outside each edge, then the far corner
      pxn = 12'd100;
      px(120, 405, 12'hFFF);
      px(99, 405, 12'hFFF);
      px(110, 420, 12'hFFF);
      px(110, 399, 12'hFFF);
      fend(1'b0);
      px(119, 419, 12'hFFF);
      xl = 3'd1;
      fend(1'b1);

      // flash window then reset mid-cooldown
      pxe(110, 410, 12'hFFF, fl(12'hFFF));
      pxe(110, 410, 12'h123, fl(12'h123));
      px(50, 50, 12'h123);
      do_rst(2);
      px(110, 410, 12'hFFF);
      fend(1'b0);
      px(0, 0, 12'h000);
      fend(1'b0);
      repeat (4) px(0, 0, 12'h000);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge pclk);
      if (q.size() > 0) begin
         nerr++;
         $display("FAIL drain: %0d pending, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
